skip_table_programmer: RTL and testbench

//  Writer side of the fetch-stage skip-table write port (WriteEn/WriteAddress/WriteData). Accepts

---
 rtl/skip_table_programmer.sv | 167 ++++++++++++++++
 tb/tb_skip_table_programmer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/skip_table_programmer.sv
// Skip-table write sequencer: program (2 writes, or 3 with SKIP_PROG_SAFE_SEQ_EN), invalidate, clear-all.
// First write issues the cycle after accept; StallIn holds the current write; not ready while busy.
module skip_table_programmer #(
    parameter int          SKIP_TABLE_SIZE = 16,
    parameter logic [31:0] TABLE_BLOCK_IDX = 32'h1,
    localparam int         IW              = $clog2(SKIP_TABLE_SIZE)
) (
    input  logic          ClockIn,
    input  logic          AsyncResetIn,
    input  logic          ReqValidIn,
    output logic          ReqReadyOut,
    input  logic [1:0]    ReqOpIn,
    input  logic [IW-1:0] ReqIdxIn,
    input  logic [31:0]   ReqPCIn,
    input  logic [31:0]   ReqEntryIn,
    input  logic          StallIn,
    output logic          WriteEnOut,
    output logic [31:0]   WriteAddressOut,
    output logic [31:0]   WriteDataOut,
    output logic          BusyOut,
    output logic          DoneOut,
    output logic          ErrOut
);

    localparam logic [29-IW:0] BLK      = TABLE_BLOCK_IDX[29-IW:0];
    localparam logic [IW-1:0]  LAST_IDX = IW'(SKIP_TABLE_SIZE - 1);

    localparam logic [1:0] OP_PROG = 2'b00;
    localparam logic [1:0] OP_INV  = 2'b01;
    localparam logic [1:0] OP_CLR  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_INV,
        S_W_PC,
        S_W_ENT,
        S_W_ENT0,
        S_CLR,
        S_ERR
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [IW-1:0] r_idx;
    logic [31:0]   r_pc;
    logic [31:0]   r_entry;
    logic [IW-1:0] r_clr_cnt;
    logic          w_accept;
    logic          w_clr_issue;
    logic [31:0]   w_entry_clean;
    logic          w_we;
    logic [31:0]   w_addr;
    logic [31:0]   w_data;
    logic          w_done;
    logic          w_err;

    function automatic logic [31:0] f_addr(input logic [IW-1:0] idx, input logic off);
        return {BLK, 1'b0, idx, off};
    endfunction

    assign ReqReadyOut   = (r_state == S_IDLE) && !AsyncResetIn;
    assign BusyOut       = (r_state != S_IDLE);
    assign w_accept      = ReqValidIn && ReqReadyOut;
    // Reserved bits [11:8] of the entry word are always written as zero.
    assign w_entry_clean = ReqEntryIn & 32'hFFFF_F0FF;
    assign w_clr_issue   = (r_state == S_CLR) && !StallIn;

    always_ff @(posedge ClockIn or posedge AsyncResetIn) begin
        if (AsyncResetIn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge ClockIn or posedge AsyncResetIn) begin
        if (AsyncResetIn) begin
            r_idx   <= '0;
            r_pc    <= '0;
            r_entry <= '0;
        end else if (w_accept) begin
            r_idx   <= ReqIdxIn;
            r_pc    <= ReqPCIn;
            r_entry <= w_entry_clean;
        end
    end

    always_ff @(posedge ClockIn or posedge AsyncResetIn) begin
        if (AsyncResetIn) begin
            r_clr_cnt <= '0;
        end else if (w_clr_issue) begin
            r_clr_cnt <= (r_clr_cnt == LAST_IDX) ? '0 : r_clr_cnt + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_we        = 1'b0;
        w_addr      = '0;
        w_data      = '0;
        w_done      = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (ReqOpIn)
`ifdef SKIP_PROG_SAFE_SEQ_EN
                        OP_PROG: w_state_nxt = S_W_INV;
`else
                        OP_PROG: w_state_nxt = S_W_PC;
`endif
                        OP_INV:  w_state_nxt = S_W_ENT0;
                        OP_CLR:  w_state_nxt = S_CLR;
                        default: w_state_nxt = S_ERR;
                    endcase
                end
            end
            S_W_INV: begin
                // Kill the old entry first so the CAM never pairs the new PC with stale valid data.
                w_we   = !StallIn;
                w_addr = f_addr(r_idx, 1'b1);
                w_data = {1'b0, r_entry[30:0]};
                if (!StallIn) w_state_nxt = S_W_PC;
            end
            S_W_PC: begin
                w_we   = !StallIn;
                w_addr = f_addr(r_idx, 1'b0);
                w_data = r_pc;
                if (!StallIn) w_state_nxt = S_W_ENT;
            end
            S_W_ENT: begin
                w_we   = !StallIn;
                w_addr = f_addr(r_idx, 1'b1);
                w_data = r_entry;
                w_done = !StallIn;
                if (!StallIn) w_state_nxt = S_IDLE;
            end
            S_W_ENT0: begin
                w_we   = !StallIn;
                w_addr = f_addr(r_idx, 1'b1);
                w_done = !StallIn;
                if (!StallIn) w_state_nxt = S_IDLE;
            end
            S_CLR: begin
                w_we   = !StallIn;
                w_addr = f_addr(r_clr_cnt, 1'b1);
                if (w_clr_issue && (r_clr_cnt == LAST_IDX)) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_ERR: begin
                w_err       = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are forced low for the whole reset window, not just from the next edge.
    assign WriteEnOut      = w_we   && !AsyncResetIn;
    assign WriteAddressOut = AsyncResetIn ? '0 : w_addr;
    assign WriteDataOut    = AsyncResetIn ? '0 : w_data;
    assign DoneOut         = w_done && !AsyncResetIn;
    assign ErrOut          = w_err  && !AsyncResetIn;

endmodule

// File: tb/tb_skip_table_programmer.sv
// Randomized bench for skip_table_programmer against a write-list reference model.
module tb_skip_table_programmer;

    localparam int          SIZE = 16;
    localparam int          IW   = 4;
    localparam logic [31:0] BLK  = 32'h1;

    logic          ClockIn      = 1'b0;
    logic          AsyncResetIn = 1'b1;
    logic          ReqValidIn   = 1'b0;
    logic [1:0]    ReqOpIn      = '0;
    logic [IW-1:0] ReqIdxIn     = '0;
    logic [31:0]   ReqPCIn      = '0;
    logic [31:0]   ReqEntryIn   = '0;
    logic          StallIn      = 1'b0;
    logic          ReqReadyOut;
    logic          WriteEnOut;
    logic [31:0]   WriteAddressOut;
    logic [31:0]   WriteDataOut;
    logic          BusyOut;
    logic          DoneOut;
    logic          ErrOut;

    int n_tests = 0;
    int n_fail  = 0;

    skip_table_programmer #(
        .SKIP_TABLE_SIZE (SIZE),
        .TABLE_BLOCK_IDX (BLK)
    ) dut (
        .ClockIn         (ClockIn),
        .AsyncResetIn    (AsyncResetIn),
        .ReqValidIn      (ReqValidIn),
        .ReqReadyOut     (ReqReadyOut),
        .ReqOpIn         (ReqOpIn),
        .ReqIdxIn        (ReqIdxIn),
        .ReqPCIn         (ReqPCIn),
        .ReqEntryIn      (ReqEntryIn),
        .StallIn         (StallIn),
        .WriteEnOut      (WriteEnOut),
        .WriteAddressOut (WriteAddressOut),
        .WriteDataOut    (WriteDataOut),
        .BusyOut         (BusyOut),
        .DoneOut         (DoneOut),
        .ErrOut          (ErrOut)
    );

    always #5 ClockIn = ~ClockIn;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] taddr(input int idx, input int off);
        return (BLK << (IW + 2)) + 32'(idx * 2) + 32'(off);
    endfunction

    task automatic drive_junk();
        ReqValidIn = 1'($urandom_range(0, 1));
        ReqOpIn    = 2'($urandom_range(0, 3));
        ReqIdxIn   = IW'($urandom_range(0, SIZE - 1));
        ReqPCIn    = $urandom;
        ReqEntryIn = $urandom;
    endtask

    // Builds the ordered list of table writes a command must produce, then checks cycle by cycle.
    task automatic run_cmd(input logic [1:0] op, input int idx, input logic [31:0] pc,
                           input logic [31:0] ent, input logic [31:0] smask, input int spct);
        logic [31:0] qa[$];
        logic [31:0] qd[$];
        logic [31:0] clean;
        bit          err_pend;
        int          cyc;
        clean    = ent & 32'hFFFF_F0FF;
        err_pend = 1'b0;
        case (op)
            2'b00: begin
`ifdef SKIP_PROG_SAFE_SEQ_EN
                qa.push_back(taddr(idx, 1)); qd.push_back(clean & 32'h7FFF_FFFF);
`endif
                qa.push_back(taddr(idx, 0)); qd.push_back(pc);
                qa.push_back(taddr(idx, 1)); qd.push_back(clean);
            end
            2'b01: begin
                qa.push_back(taddr(idx, 1)); qd.push_back(32'h0);
            end
            2'b10: begin
                for (int i = 0; i < SIZE; i++) begin
                    qa.push_back(taddr(i, 1)); qd.push_back(32'h0);
                end
            end
            default: err_pend = 1'b1;
        endcase

        @(negedge ClockIn);
        ReqValidIn = 1'b1;
        ReqOpIn    = op;
        ReqIdxIn   = IW'(idx);
        ReqPCIn    = pc;
        ReqEntryIn = ent;
        StallIn    = 1'($urandom_range(0, 1));
        #1;
        check("ready_idle", 32'(ReqReadyOut), 32'd1);
        check("we_idle", 32'(WriteEnOut), 32'd0);

        cyc = 0;
        while ((qa.size() > 0 || err_pend) && cyc < 300) begin
            @(negedge ClockIn);
            drive_junk();
            StallIn = ((cyc < 32) && smask[cyc]) || (int'($urandom_range(0, 99)) < spct);
            #1;
            check("busy", 32'(BusyOut), 32'd1);
            check("ready_busy", 32'(ReqReadyOut), 32'd0);
            if (err_pend) begin
                check("err_pulse", 32'(ErrOut), 32'd1);
                check("err_we", 32'(WriteEnOut), 32'd0);
                check("err_done", 32'(DoneOut), 32'd0);
                err_pend = 1'b0;
            end else begin
                check("err_quiet", 32'(ErrOut), 32'd0);
                check("wr_addr", WriteAddressOut, qa[0]);
                check("wr_data", WriteDataOut, qd[0]);
                if (StallIn) begin
                    check("stall_we", 32'(WriteEnOut), 32'd0);
                    check("stall_done", 32'(DoneOut), 32'd0);
                end else begin
                    check("wr_en", 32'(WriteEnOut), 32'd1);
                    check("done", 32'(DoneOut), 32'(qa.size() == 1));
                    void'(qa.pop_front());
                    void'(qd.pop_front());
                end
            end
            cyc++;
        end
        check("writes_left", 32'(qa.size()), 32'd0);

        @(negedge ClockIn);
        ReqValidIn = 1'b0;
        StallIn    = 1'b0;
        #1;
        check("ready_after", 32'(ReqReadyOut), 32'd1);
        check("busy_after", 32'(BusyOut), 32'd0);
        check("we_after", 32'(WriteEnOut), 32'd0);
        check("err_after", 32'(ErrOut), 32'd0);
    endtask

    // Program command interrupted by reset while its PC write is presented.
    task automatic reset_mid(input int idx);
        int n_pre;
`ifdef SKIP_PROG_SAFE_SEQ_EN
        n_pre = 1;
`else
        n_pre = 0;
`endif
        @(negedge ClockIn);
        ReqValidIn = 1'b1;
        ReqOpIn    = 2'b00;
        ReqIdxIn   = IW'(idx);
        ReqPCIn    = $urandom;
        ReqEntryIn = $urandom;
        StallIn    = 1'b0;
        for (int i = 0; i < n_pre; i++) begin
            @(negedge ClockIn);
            ReqValidIn = 1'b0;
            #1;
            check("rst_pre_we", 32'(WriteEnOut), 32'd1);
        end
        @(negedge ClockIn);
        ReqValidIn = 1'b0;
        #1;
        check("rst_wpc_addr", WriteAddressOut, taddr(idx, 0));
        AsyncResetIn = 1'b1;
        #1;
        check("rst_we", 32'(WriteEnOut), 32'd0);
        check("rst_ready", 32'(ReqReadyOut), 32'd0);
        check("rst_busy", 32'(BusyOut), 32'd0);
        check("rst_done", 32'(DoneOut), 32'd0);
        @(negedge ClockIn);
        AsyncResetIn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge ClockIn);
            #1;
            check("post_rst_we", 32'(WriteEnOut), 32'd0);
            check("post_rst_ready", 32'(ReqReadyOut), 32'd1);
            check("post_rst_busy", 32'(BusyOut), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] stall_mask;
        logic [1:0]  op;
`ifdef SKIP_PROG_SAFE_SEQ_EN
        stall_mask = 32'h6;
`else
        stall_mask = 32'h3;
`endif
        repeat (2) @(negedge ClockIn);
        #1;
        check("reset_ready", 32'(ReqReadyOut), 32'd0);
        check("reset_we", 32'(WriteEnOut), 32'd0);
        check("reset_addr", WriteAddressOut, 32'd0);
        check("reset_data", WriteDataOut, 32'd0);
        check("reset_busy", 32'(BusyOut), 32'd0);
        check("reset_done", 32'(DoneOut), 32'd0);
        check("reset_err", 32'(ErrOut), 32'd0);
        @(negedge ClockIn);
        AsyncResetIn = 1'b0;

        run_cmd(2'b00, 3, 32'h100, 32'h8A12_3405, 32'h0, 0);
        run_cmd(2'b00, 3, 32'h100, 32'h8A12_3405, stall_mask, 0);
        run_cmd(2'b10, 0, 32'h0, 32'h0, 32'h0, 0);
        run_cmd(2'b01, 7, 32'h0, 32'h0, 32'h0, 0);
        run_cmd(2'b11, 5, 32'h0, 32'h0, 32'h0, 0);
        reset_mid(9);
        run_cmd(2'b00, SIZE - 1, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'h0, 0);

        for (int n = 0; n < 40; n++) begin
            op = 2'($urandom_range(0, 3));
            run_cmd(op, int'($urandom_range(0, SIZE - 1)), $urandom, $urandom,
                    $urandom, int'($urandom_range(0, 50)));
        end
        run_cmd(2'b10, 0, 32'h0, 32'h0, 32'h0, 40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
